// File: rtl/matmul_pipe_if.sv
// matmul_pipe_if: operand / result handshake bundle for matmul_pipe.
//   A_flat, B_flat  operand matrices, element (i,j) at [(i*N+j)*WIDTH +: WIDTH]
//   s_valid/s_ready operand handshake
//   C_flat          result matrix, element (i,j) at [(i*N+j)*OUT_W +: OUT_W]
//   m_valid/m_ready result handshake
// Modports:
//   master  the environment around the multiplier (drives operands and m_ready)
//   slave   the multiplier itself
interface matmul_pipe_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OUT_W = 2 * WIDTH + $clog2(N)
);
    logic [N*N*WIDTH-1:0] A_flat;
    logic [N*N*WIDTH-1:0] B_flat;
    logic                 s_valid;
    logic                 s_ready;
    logic [N*N*OUT_W-1:0] C_flat;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output A_flat, B_flat, s_valid, m_ready,
        input  s_ready, C_flat, m_valid
    );

    modport slave (
        input  A_flat, B_flat, s_valid, m_ready,
        output s_ready, C_flat, m_valid
    );
endinterface

// File: rtl/matmul_pipe.sv
// matmul_pipe: fully pipelined N x N matrix multiplier, C = A * B.
//   Stage 0 registers all N^3 products, stages 1..$clog2(N) form a registered pairwise adder
//   tree per result element. Latency 1+$clog2(N), one matrix pair per cycle, global stall on
//   back-pressure. Output width reduction (saturate or wrap) is combinational after the tree.
// Ports:
//   clk   clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   matmul_pipe_if slave: operands + s_valid/s_ready in, C_flat + m_valid/m_ready out
module matmul_pipe #(
    parameter int unsigned N        = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned OUT_W    = 2 * WIDTH + $clog2(N),
    parameter bit          SIGNED   = 1'b0,
    parameter bit          SATURATE = 1'b1
) (
    input logic          clk,
    input logic          rstn,
    matmul_pipe_if.slave bus
);
    localparam int unsigned T     = $clog2(N);
    localparam int unsigned P     = 1 << T;            // product count padded to a power of 2
    localparam int unsigned NE    = N * N;
    localparam int unsigned FullW = 2 * WIDTH + T;
    // One spare bit so signed compares against the clamp bounds never overflow
    localparam int unsigned WideW = ((FullW > OUT_W) ? FullW : OUT_W) + 1;

    // Level 0 holds products, level l holds P>>l partial sums; all kept at full precision
    // (sign-extended when SIGNED) so one add width serves every level.
    logic [FullW-1:0] sum_q [T+1][NE][P];
    logic [T:0]       valid_q;
    logic             en;

    assign en          = !valid_q[T] || bus.m_ready;
    assign bus.s_ready = en;
    assign bus.m_valid = valid_q[T];

    function automatic logic [FullW-1:0] mul_ext(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ae;
        logic [2*WIDTH-1:0] be;
        logic [2*WIDTH-1:0] p;
        if (SIGNED) begin
            ae = {{WIDTH{a[WIDTH-1]}}, a};
            be = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            ae = {{WIDTH{1'b0}}, a};
            be = {{WIDTH{1'b0}}, b};
        end
        // Low 2*WIDTH bits of the extended product are correct for both signednesses
        p = ae * be;
        if (SIGNED) mul_ext = FullW'($signed(p));
        else        mul_ext = FullW'(p);
    endfunction

    function automatic logic [OUT_W-1:0] fit(input logic [FullW-1:0] s);
        logic [WideW-1:0] w;
        logic [WideW-1:0] hi;
        logic [OUT_W-1:0] r;
        if (SIGNED) w = WideW'($signed(s));
        else        w = WideW'(s);
        r = w[OUT_W-1:0];
        if (SATURATE && (OUT_W < FullW)) begin
            if (SIGNED) begin
                hi = (WideW'(1) << (OUT_W - 1)) - WideW'(1);
                // ~hi is the most negative representable value
                if ($signed(w) > $signed(hi))       r = hi[OUT_W-1:0];
                else if ($signed(w) < $signed(~hi)) r = ~hi[OUT_W-1:0];
            end else begin
                hi = (WideW'(1) << OUT_W) - WideW'(1);
                if (w > hi) r = '1;
            end
        end
        fit = r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int unsigned l = 0; l <= T; l++) begin
                for (int unsigned e = 0; e < NE; e++) begin
                    for (int unsigned k = 0; k < P; k++) begin
                        sum_q[l][e][k] <= '0;
                    end
                end
            end
        end else if (en) begin
            valid_q[0] <= bus.s_valid;
            for (int unsigned l = 1; l <= T; l++) begin
                valid_q[l] <= valid_q[l-1];
            end
            // Padding slots k >= N are never written and stay zero from reset
            for (int unsigned e = 0; e < NE; e++) begin
                for (int unsigned k = 0; k < N; k++) begin
                    sum_q[0][e][k] <= mul_ext(bus.A_flat[((e / N) * N + k) * WIDTH +: WIDTH],
                                              bus.B_flat[(k * N + (e % N)) * WIDTH +: WIDTH]);
                end
            end
            for (int unsigned l = 1; l <= T; l++) begin
                for (int unsigned e = 0; e < NE; e++) begin
                    for (int unsigned k = 0; k < (P >> l); k++) begin
                        sum_q[l][e][k] <= sum_q[l-1][e][2*k] + sum_q[l-1][e][2*k+1];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.C_flat = '0;
        for (int unsigned e = 0; e < NE; e++) begin
            bus.C_flat[e*OUT_W +: OUT_W] = fit(sum_q[T][e][0]);
        end
    end
endmodule
